// File: rtl/serial_subtractor_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
// FSM state encoding and the default operand width.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bin, with borrow-out.
// Reused every cycle by the serial datapath.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor, LSB first, with start/ready/done handshake.
// Results are held between operations and only update as DONE is entered.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             overflow,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] a_reg, b_reg, part_reg, diff_reg;
    logic             br_reg, bout_reg, ovf_reg;
    logic [CW-1:0]    cnt_reg;
    logic             d_bit, br_next, last_bit;

    full_subtractor u_full_subtractor (
        .a    (a_reg[0]),
        .b    (b_reg[0]),
        .bin  (br_reg),
        .d    (d_bit),
        .bout (br_next)
    );

    assign last_bit = (cnt_reg == CW'(WIDTH - 1));

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (last_bit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg    <= '0;
            b_reg    <= '0;
            part_reg <= '0;
            br_reg   <= 1'b0;
            cnt_reg  <= '0;
            diff_reg <= '0;
            bout_reg <= 1'b0;
            ovf_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        a_reg   <= a;
                        b_reg   <= b;
                        br_reg  <= bin;
                        cnt_reg <= '0;
                    end
                end
                SHIFT: begin
                    part_reg <= {d_bit, part_reg[WIDTH-1:1]};
                    a_reg    <= a_reg >> 1;
                    b_reg    <= b_reg >> 1;
                    br_reg   <= br_next;
                    cnt_reg  <= cnt_reg + CW'(1);
                    if (last_bit) begin
                        // br_reg here is the borrow into the MSB cell
                        diff_reg <= {d_bit, part_reg[WIDTH-1:1]};
                        bout_reg <= br_next;
                        ovf_reg  <= br_reg ^ br_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ready    = (state_reg == IDLE);
    assign done     = (state_reg == DONE);
    assign diff     = diff_reg;
    assign bout     = bout_reg;
    assign overflow = ovf_reg;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed vectors, mid-op start,
// back-to-back streaming, reset mid-operation and random operands.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         bin = 1'b0;
    logic         ready;
    logic [W-1:0] diff;
    logic         bout;
    logic         overflow;
    logic         done;

    int checks = 0;
    int errors = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a        (a),
        .b        (b),
        .bin      (bin),
        .ready    (ready),
        .diff     (diff),
        .bout     (bout),
        .overflow (overflow),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed views.
    function automatic void model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                                  output logic [W-1:0] d, output logic bo, output logic ov);
        int u;
        int s;
        u  = int'(x) - int'(y) - int'(c);
        s  = int'($signed(x)) - int'($signed(y)) - int'(c);
        d  = u[W-1:0];
        bo = (u < 0);
        ov = (s > 127) || (s < -128);
    endfunction

    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tbin,
                         input bit inject);
        logic [W-1:0] ed;
        logic         eb, eo;
        int           lat;
        bit           got;
        model(ta, tb_v, tbin, ed, eb, eo);
        @(negedge clk);
        a = ta; b = tb_v; bin = tbin; start = 1'b1;
        chk("ready_before_start", 32'(ready), 32'd1);
        @(posedge clk); #1;
        start = 1'b0; a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
        chk("ready_busy", 32'(ready), 32'd0);
        lat = 0; got = 0;
        while (!got && lat < 20) begin
            @(posedge clk); lat++; #1;
            if (done) got = 1;
            else if (inject && lat == 3) begin
                start = 1'b1; a = 8'd9; b = 8'd5; bin = 1'b0;
            end else start = 1'b0;
        end
        start = 1'b0;
        chk("latency", 32'(lat), 32'(W));
        chk("diff", 32'(diff), 32'(ed));
        chk("bout", 32'(bout), 32'(eb));
        chk("overflow", 32'(overflow), 32'(eo));
        $display("op a=%0d b=%0d bin=%0d -> diff=%0d bout=%0d ovf=%0d lat=%0d",
                 ta, tb_v, tbin, diff, bout, overflow, lat);
        @(posedge clk); #1;
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("ready_after", 32'(ready), 32'd1);
    endtask

    initial begin
        logic [2*W:0] q[$];
        logic [2*W:0] e;
        logic [W-1:0] ed;
        logic         eb, eo;
        int           pushes, dones, last_done;

        // Reset state
        #1;
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_diff", 32'(diff), 32'd0);
        chk("rst_bout", 32'(bout), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors
        do_op(8'd81, 8'd18, 1'b1, 0);
        do_op(8'd35, 8'd45, 1'b0, 0);
        do_op(8'h80, 8'h01, 1'b0, 0);
        do_op(8'h7F, 8'hFF, 1'b0, 0);
        do_op(8'h00, 8'h00, 1'b1, 0);
        do_op(8'hFF, 8'hFF, 1'b0, 0);
        do_op(8'h80, 8'h00, 1'b1, 0);

        // start pulsed mid-operation must be ignored
        do_op(8'd56, 8'd7, 1'b1, 1);
        repeat (W + 3) begin
            @(posedge clk); #1;
            chk("no_spurious_done", 32'(done), 32'd0);
        end

        // start held high: three back-to-back operations
        pushes = 0; dones = 0; last_done = -1;
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(negedge clk);
            if (done) begin
                if (q.size() > 0) begin
                    e = q.pop_front();
                    model(e[2*W:W+1], e[W:1], e[0], ed, eb, eo);
                    chk("stream_diff", 32'(diff), 32'(ed));
                    chk("stream_bout", 32'(bout), 32'(eb));
                    chk("stream_ovf", 32'(overflow), 32'(eo));
                    $display("stream a=%0d b=%0d bin=%0d -> diff=%0d", e[2*W:W+1], e[W:1], e[0], diff);
                end
                if (last_done >= 0) chk("stream_spacing", 32'(cyc - last_done), 32'(W + 2));
                last_done = cyc;
                dones++;
            end
            if (pushes < 3) begin
                start = 1'b1; a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
                if (ready) begin
                    q.push_back({a, b, bin});
                    pushes++;
                end
            end else start = 1'b0;
        end
        chk("stream_done_count", 32'(dones), 32'd3);
        chk("stream_queue_empty", 32'(q.size()), 32'd0);

        // Reset mid-operation
        @(negedge clk);
        a = 8'd70; b = 8'd19; bin = 1'b0; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0; #1;
        chk("midrst_ready", 32'(ready), 32'd1);
        chk("midrst_diff", 32'(diff), 32'd0);
        chk("midrst_bout", 32'(bout), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        $display("reset asserted mid-operation");
        repeat (2) begin
            @(posedge clk); #1;
            chk("rst_hold_done", 32'(done), 32'd0);
        end
        @(negedge clk); rst_n = 1'b1;
        do_op(8'd44, 8'd13, 1'b1, 0);

        // Random operands
        for (int i = 0; i < 12; i++)
            do_op(W'($urandom), W'($urandom), 1'($urandom), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
